// File: rtl/sap_core.sv
// sap_core: parametrised multi-cycle accumulator CPU with on-chip program RAM,
// a programming port, run/pause control, an output register and halt state.
// Optional feature macro: SAP_FLAGS_EN adds carry/zero flags and makes
// JC/JZ conditional branches; without it opcodes 7 and 8 behave as NOPs.
// DATA_W must be at least 4 + ADDR_W so opcode and operand fit in one word.
module sap_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [DATA_W-1:0] i_prog_data,
  output logic [DATA_W-1:0] o_out,
  output logic              o_out_valid,
  output logic              o_halted,
  output logic [ADDR_W-1:0] o_pc
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
`ifdef SAP_FLAGS_EN
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
`endif
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_HALT
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_out;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [3:0]        w_opcode;
  logic [ADDR_W-1:0] w_operand;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_mem_rd;
  logic              w_is_sub;
  logic [DATA_W-1:0] w_b_op;
  logic [DATA_W-1:0] w_result;
  logic              w_prog_ok;

  assign w_opcode  = r_ir[DATA_W-1 -: 4];
  assign w_operand = r_ir[ADDR_W-1:0];
  assign w_imm     = DATA_W'(r_ir[DATA_W-5:0]);
  assign w_mem_rd  = r_mem[r_mar];
  assign w_is_sub  = (w_opcode == OP_SUB);
  assign w_b_op    = w_is_sub ? ~r_b : r_b;

  // Programming writes only land while the core is idle and not running,
  // which also keeps them from ever colliding with an STA.
  assign w_prog_ok = i_prog_we && !i_run && (r_state == ST_T0 || r_state == ST_HALT);

`ifdef SAP_FLAGS_EN
  logic              r_c;
  logic              r_z;
  logic [DATA_W:0]   w_sum;
  assign w_sum    = {1'b0, r_a} + {1'b0, w_b_op} + (DATA_W+1)'(w_is_sub);
  assign w_result = w_sum[DATA_W-1:0];
`else
  assign w_result = r_a + w_b_op + DATA_W'(w_is_sub);
`endif

  // State register for the microsequencer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_T0;
    else       r_state <= w_next_state;
  end

  // Next-state logic: T0 waits for run, HLT diverts at T2, HALT is sticky.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_T0:   if (i_run) w_next_state = ST_T1;
      ST_T1:   w_next_state = ST_T2;
      ST_T2:   w_next_state = (w_opcode == OP_HLT) ? ST_HALT : ST_T3;
      ST_T3:   w_next_state = ST_T4;
      ST_T4:   w_next_state = ST_T0;
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_T0;
    endcase
  end

  // Datapath registers: fetch, decode/execute micro-steps and output strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc        <= '0;
      r_mar       <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
`ifdef SAP_FLAGS_EN
      r_c         <= 1'b0;
      r_z         <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_T0: if (i_run) r_mar <= r_pc;
        ST_T1: begin
          r_ir <= w_mem_rd;
          r_pc <= r_pc + ADDR_W'(1);
        end
        ST_T2: begin
          case (w_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: r_mar <= w_operand;
            OP_LDI: r_a  <= w_imm;
            OP_JMP: r_pc <= w_operand;
`ifdef SAP_FLAGS_EN
            OP_JC:  if (r_c) r_pc <= w_operand;
            OP_JZ:  if (r_z) r_pc <= w_operand;
`endif
            OP_OUT: begin
              r_out       <= r_a;
              r_out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_T3: begin
          case (w_opcode)
            OP_LDA:         r_a <= w_mem_rd;
            OP_ADD, OP_SUB: r_b <= w_mem_rd;
            default: ;
          endcase
        end
        ST_T4: begin
          if (w_opcode == OP_ADD || w_opcode == OP_SUB) begin
            r_a <= w_result;
`ifdef SAP_FLAGS_EN
            r_c <= w_sum[DATA_W];
            r_z <= (w_result == '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Program RAM writes: STA in T3 or an accepted programming-port write.
  // Contents are deliberately not reset so a reset keeps the program.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_T3 && w_opcode == OP_STA) r_mem[r_mar] <= r_a;
    else if (w_prog_ok)                         r_mem[i_prog_addr] <= i_prog_data;
  end

  assign o_out       = r_out;
  assign o_out_valid = r_out_valid;
  assign o_halted    = (r_state == ST_HALT);
  assign o_pc        = r_pc;

endmodule

// File: tb/tb_sap_core.sv
// tb_sap_core: self-checking bench for sap_core with an output scoreboard.
// Works with or without SAP_FLAGS_EN; expectations follow the macro.
module tb_sap_core;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_run;
  logic              i_prog_we;
  logic [ADDR_W-1:0] i_prog_addr;
  logic [DATA_W-1:0] i_prog_data;
  logic [DATA_W-1:0] o_out;
  logic              o_out_valid;
  logic              o_halted;
  logic [ADDR_W-1:0] o_pc;

  int                checks   = 0;
  int                failures = 0;
  logic [DATA_W-1:0] scoreQ[$];
  logic [DATA_W-1:0] img[16];
  logic [DATA_W-1:0] expOut;
  logic              prevValid = 1'b0;
  int                edgeNum;

  sap_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_run      (i_run),
    .i_prog_we  (i_prog_we),
    .i_prog_addr(i_prog_addr),
    .i_prog_data(i_prog_data),
    .o_out      (o_out),
    .o_out_valid(o_out_valid),
    .o_halted   (o_halted),
    .o_pc       (o_pc)
  );

  // Free-running clock, 10 time units per period.
  always #5 i_clk = ~i_clk;

  // Scoreboard consumer: every output pulse must match the next queued value
  // and must never last longer than one cycle.
  always @(negedge i_clk) begin
    if (o_out_valid) begin
      checks++;
      if (prevValid) begin
        failures++;
        $display("[TB] FAIL valid_width: o_out_valid high=%0d cycles, required 1", 2);
      end
      checks++;
      if (scoreQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL out_unexpected: got o_out=%0h, required no pulse", o_out);
      end else begin
        expOut = scoreQ.pop_front();
        if (o_out !== expOut) begin
          failures++;
          $display("[TB] FAIL out_value: got %0h, required %0h", o_out, expOut);
        end
      end
    end
    prevValid = o_out_valid;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    i_run     = 1'b0;
    i_prog_we = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    #2;
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    i_prog_we   = 1'b1;
    i_prog_addr = addr;
    i_prog_data = data;
    @(negedge i_clk);
    i_prog_we   = 1'b0;
  endtask

  task automatic load_img();
    for (int i = 0; i < 16; i++) write_word(ADDR_W'(i), img[i]);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = '0;
  endtask

  task automatic start_run();
    i_run   = 1'b1;
    edgeNum = 0;
  endtask

  task automatic goto_edge(input int target);
    repeat (target - edgeNum) @(posedge i_clk);
    edgeNum = target;
    @(negedge i_clk);
  endtask

  task automatic wait_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (o_halted) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    i_run = 1'b0;
  endtask

  task automatic test_reset();
    i_rst       = 1'b1;
    i_run       = 1'b0;
    i_prog_we   = 1'b0;
    i_prog_addr = '0;
    i_prog_data = '0;
    #1;
    checks++; if (o_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_out: got %0h, required 0", o_out); end
    checks++; if (o_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b, required 0", o_out_valid); end
    checks++; if (o_halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted: got %0b, required 0", o_halted); end
    checks++; if (o_pc !== 4'h0) begin failures++; $display("[TB] FAIL reset_pc: got %0h, required 0", o_pc); end
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic load_scenario1();
    clear_img();
    img[0] = 8'h55; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0; img[15] = 8'h03;
    load_img();
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (scoreQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_missing_out: pending=%0d, required 0", name, scoreQ.size());
    end
    scoreQ.delete();
  endtask

  task automatic test_add_out_halt();
    do_reset();
    load_scenario1();
    scoreQ.push_back(8'h08);
    start_run();
    goto_edge(12);
    checks++; if (o_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_valid_e12: got %0b, required 0", o_out_valid); end
    goto_edge(13);
    checks++; if (o_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL add_valid_e13: got %0b, required 1", o_out_valid); end
    goto_edge(14);
    checks++; if (o_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_valid_e14: got %0b, required 0", o_out_valid); end
    goto_edge(17);
    checks++; if (o_halted !== 1'b0) begin failures++; $display("[TB] FAIL add_halted_e17: got %0b, required 0", o_halted); end
    goto_edge(18);
    checks++; if (o_halted !== 1'b1) begin failures++; $display("[TB] FAIL add_halted_e18: got %0b, required 1", o_halted); end
    checks++; if (o_pc !== 4'h4) begin failures++; $display("[TB] FAIL add_pc: got %0h, required 4", o_pc); end
    goto_edge(25);
    checks++; if (o_halted !== 1'b1) begin failures++; $display("[TB] FAIL add_halt_sticky: got %0b, required 1", o_halted); end
    checks++; if (o_out !== 8'h08) begin failures++; $display("[TB] FAIL add_out_hold: got %0h, required 08", o_out); end
    i_run = 1'b0;
    check_queue_empty("add");
  endtask

  task automatic test_wrap_carry();
    bit ok;
    logic [ADDR_W-1:0] expPc;
    do_reset();
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h74; img[3] = 8'hF0;
    img[4] = 8'hE0; img[5] = 8'hF0; img[14] = 8'hFF; img[15] = 8'h01;
    load_img();
`ifdef SAP_FLAGS_EN
    scoreQ.push_back(8'h00);
    expPc = 4'h6;
`else
    expPc = 4'h4;
`endif
    start_run();
    wait_halt(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL wrap_halt_timeout: halted=%0b, required 1", o_halted); end
    checks++; if (o_pc !== expPc) begin failures++; $display("[TB] FAIL wrap_pc: got %0h, required %0h", o_pc, expPc); end
    check_queue_empty("wrap");
  endtask

  task automatic test_sub_jz();
    bit ok;
    logic [ADDR_W-1:0] expPc;
    do_reset();
    clear_img();
    img[0] = 8'h53; img[1] = 8'h3F; img[2] = 8'h85; img[3] = 8'hF0;
    img[4] = 8'h00; img[5] = 8'hE0; img[6] = 8'hF0; img[15] = 8'h03;
    load_img();
`ifdef SAP_FLAGS_EN
    scoreQ.push_back(8'h00);
    expPc = 4'h7;
`else
    expPc = 4'h4;
`endif
    start_run();
    wait_halt(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL subjz_halt_timeout: halted=%0b, required 1", o_halted); end
    checks++; if (o_pc !== expPc) begin failures++; $display("[TB] FAIL subjz_pc: got %0h, required %0h", o_pc, expPc); end
    check_queue_empty("subjz");
  endtask

  task automatic test_sta_lda();
    bit ok;
    do_reset();
    clear_img();
    img[0] = 8'h57; img[1] = 8'h4D; img[2] = 8'h50; img[3] = 8'h1D;
    img[4] = 8'hE0; img[5] = 8'hF0;
    load_img();
    scoreQ.push_back(8'h07);
    start_run();
    wait_halt(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL sta_halt_timeout: halted=%0b, required 1", o_halted); end
    checks++; if (o_pc !== 4'h6) begin failures++; $display("[TB] FAIL sta_pc: got %0h, required 6", o_pc); end
    checks++; if (o_out !== 8'h07) begin failures++; $display("[TB] FAIL sta_out: got %0h, required 07", o_out); end
    check_queue_empty("sta");
  endtask

  task automatic test_pc_wrap_pause();
    bit ok;
    do_reset();
    clear_img();
    load_img();
    start_run();
    goto_edge(72);
    checks++; if (o_pc !== 4'hF) begin failures++; $display("[TB] FAIL wrap_pc_e72: got %0h, required f", o_pc); end
    goto_edge(80);
    checks++; if (o_pc !== 4'h0) begin failures++; $display("[TB] FAIL wrap_pc_e80: got %0h, required 0", o_pc); end
    checks++; if (o_halted !== 1'b0) begin failures++; $display("[TB] FAIL wrap_halted: got %0b, required 0", o_halted); end
    do_reset();
    start_run();
    goto_edge(7);
    i_run = 1'b0;
    checks++; if (o_pc !== 4'h2) begin failures++; $display("[TB] FAIL pause_pc_e7: got %0h, required 2", o_pc); end
    goto_edge(27);
    checks++; if (o_pc !== 4'h2) begin failures++; $display("[TB] FAIL pause_pc_hold: got %0h, required 2", o_pc); end
    write_word(4'h2, 8'h57);
    write_word(4'h3, 8'hE0);
    write_word(4'h4, 8'hF0);
    scoreQ.push_back(8'h07);
    i_run       = 1'b1;
    i_prog_we   = 1'b1;
    i_prog_addr = 4'h3;
    i_prog_data = 8'hF0;
    @(negedge i_clk);
    i_prog_we = 1'b0;
    wait_halt(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL pause_halt_timeout: halted=%0b, required 1", o_halted); end
    checks++; if (o_pc !== 4'h5) begin failures++; $display("[TB] FAIL pause_pc_final: got %0h, required 5", o_pc); end
    check_queue_empty("pause");
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    load_scenario1();
    start_run();
    goto_edge(8);
    checks++; if (o_pc !== 4'h2) begin failures++; $display("[TB] FAIL mid_pc_before: got %0h, required 2", o_pc); end
    i_rst = 1'b1;
    #1;
    checks++; if (o_pc !== 4'h0) begin failures++; $display("[TB] FAIL mid_pc_async: got %0h, required 0", o_pc); end
    checks++; if (o_out !== 8'h00) begin failures++; $display("[TB] FAIL mid_out_async: got %0h, required 0", o_out); end
    checks++; if (o_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid_async: got %0b, required 0", o_out_valid); end
    checks++; if (o_halted !== 1'b0) begin failures++; $display("[TB] FAIL mid_halted_async: got %0b, required 0", o_halted); end
    i_run = 1'b0;
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    scoreQ.push_back(8'h08);
    start_run();
    wait_halt(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL mid_halt_timeout: halted=%0b, required 1", o_halted); end
    checks++; if (o_pc !== 4'h4) begin failures++; $display("[TB] FAIL mid_pc_final: got %0h, required 4", o_pc); end
    checks++; if (o_out !== 8'h08) begin failures++; $display("[TB] FAIL mid_out_final: got %0h, required 08", o_out); end
    check_queue_empty("mid");
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_add_out_halt();
    test_wrap_carry();
    test_sub_jz();
    test_sta_lda();
    test_pc_wrap_pause();
    test_reset_mid();
    repeat (3) @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
